// File: rtl/rf_wb_scheduler.sv
// Register-file write-port scheduler: arbitrates WB, LSU and MDU writes through one
// output register, and tracks pending long-latency destinations for RAW/WAW hazards.
module rf_wb_scheduler #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              lsu_valid,
   input  logic [ADDR_W-1:0] lsu_rd,
   input  logic [DATA_W-1:0] lsu_data,
   output logic              lsu_ready,
   input  logic              mdu_valid,
   input  logic [ADDR_W-1:0] mdu_rd,
   input  logic [DATA_W-1:0] mdu_data,
   output logic              mdu_ready,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_rd,
   output logic              issue_ready,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   output logic              rs_stall,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              sb_err
);

   localparam int NREG = 1 << ADDR_W;

   typedef enum logic {RR_LSU = 1'b0, RR_MDU = 1'b1} rr_t;

   rr_t               rr_reg, rr_next;
   logic              we_reg, we_next;
   logic              long_reg, long_next;
   logic [ADDR_W-1:0] waddr_reg, waddr_next;
   logic [DATA_W-1:0] wdata_reg, wdata_next;
   logic [NREG-1:0]   pending_reg, pending_next;
   logic              sb_err_reg, sb_err_next;

   logic wb_eff, lsu_eff, mdu_eff;
   logic grant_lsu, grant_mdu;
   logic issue_fire;

   // rd=0 requests are no-ops: they never compete for the write slot
   assign wb_eff  = wb_valid  && (wb_rd  != '0);
   assign lsu_eff = lsu_valid && (lsu_rd != '0);
   assign mdu_eff = mdu_valid && (mdu_rd != '0);

   assign grant_lsu = !wb_eff && lsu_eff && (!mdu_eff || rr_reg == RR_LSU);
   assign grant_mdu = !wb_eff && mdu_eff && (!lsu_eff || rr_reg == RR_MDU);

   assign lsu_ready = grant_lsu || (lsu_valid && lsu_rd == '0);
   assign mdu_ready = grant_mdu || (mdu_valid && mdu_rd == '0);

   assign issue_ready = (issue_rd == '0) || !pending_reg[issue_rd];
   assign issue_fire  = issue_valid && issue_ready && (issue_rd != '0);

   assign rs_stall = ((rs1_addr != '0) && pending_reg[rs1_addr]) ||
                     ((rs2_addr != '0) && pending_reg[rs2_addr]);

   always_comb begin
      rr_next     = rr_reg;
      we_next     = 1'b0;
      long_next   = 1'b0;
      waddr_next  = waddr_reg;
      wdata_next  = wdata_reg;
      sb_err_next = sb_err_reg || (wb_eff && pending_reg[wb_rd]);
      if (wb_eff) begin
         we_next    = 1'b1;
         waddr_next = wb_rd;
         wdata_next = wb_data;
      end else if (grant_lsu) begin
         we_next    = 1'b1;
         long_next  = 1'b1;
         waddr_next = lsu_rd;
         wdata_next = lsu_data;
         rr_next    = RR_MDU;
      end else if (grant_mdu) begin
         we_next    = 1'b1;
         long_next  = 1'b1;
         waddr_next = mdu_rd;
         wdata_next = mdu_data;
         rr_next    = RR_LSU;
      end
   end

   // Clear happens while the long-latency write sits in the output register,
   // so stall covers the cycle before the register file commits.
   assign pending_next[0] = 1'b0;
   generate
      for (genvar gi = 1; gi < NREG; gi++) begin : g_pending
         logic set_bit, clr_bit;
         assign set_bit = issue_fire && (issue_rd == ADDR_W'(gi));
         assign clr_bit = we_reg && long_reg && (waddr_reg == ADDR_W'(gi));
         assign pending_next[gi] = set_bit || (pending_reg[gi] && !clr_bit);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_reg      <= RR_LSU;
         we_reg      <= 1'b0;
         long_reg    <= 1'b0;
         waddr_reg   <= '0;
         wdata_reg   <= '0;
         pending_reg <= '0;
         sb_err_reg  <= 1'b0;
      end else begin
         rr_reg      <= rr_next;
         we_reg      <= we_next;
         long_reg    <= long_next;
         waddr_reg   <= waddr_next;
         wdata_reg   <= wdata_next;
         pending_reg <= pending_next;
         sb_err_reg  <= sb_err_next;
      end
   end

   assign rf_we    = we_reg;
   assign rf_waddr = waddr_reg;
   assign rf_wdata = wdata_reg;
   assign sb_err   = sb_err_reg;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler: arbitration order, write latency,
// scoreboard stall/ready behaviour, error flag and mid-operation reset.
module tb_rf_wb_scheduler;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              wb_valid, lsu_valid, mdu_valid, issue_valid;
   logic [ADDR_W-1:0] wb_rd, lsu_rd, mdu_rd, issue_rd, rs1_addr, rs2_addr;
   logic [DATA_W-1:0] wb_data, lsu_data, mdu_data;
   logic              lsu_ready, mdu_ready, issue_ready, rs_stall;
   logic              rf_we, sb_err;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;

   int checks = 0;
   int errors = 0;

   rf_wb_scheduler #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
      .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs_stall(rs_stall),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .sb_err(sb_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic samp();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      wb_valid = 0; wb_rd = 0; wb_data = 0;
      lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
      mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
      issue_valid = 0; issue_rd = 0; rs1_addr = 0; rs2_addr = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      issue_rd = 5; rs1_addr = 5; rs2_addr = 6;
      samp();
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", rf_we); end
      checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr: got %0d expected 0", rf_waddr); end
      checks++; if (rf_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", rf_wdata); end
      checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL reset_sb_err: got %b expected 0", sb_err); end
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready: got %b expected 1", issue_ready); end
      checks++; if (rs_stall !== 1'b0) begin errors++; $display("FAIL reset_rs_stall: got %b expected 0", rs_stall); end
      checks++; if ({lsu_ready, mdu_ready} !== 2'b00) begin errors++; $display("FAIL reset_readies: got %b expected 00", {lsu_ready, mdu_ready}); end
      $display("test_reset: idle outputs checked");
   endtask

   task automatic test_wb_write();
      do_reset();
      wb_valid = 1; wb_rd = 5; wb_data = 32'hA5A5A5A5;
      samp();
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL wb_latency: got rf_we %b expected 0", rf_we); end
      step();
      clear_inputs();
      samp();
      checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'hA5A5A5A5})
         begin errors++; $display("FAIL wb_write: got we=%b a=%0d d=%h expected we=1 a=5 d=a5a5a5a5", rf_we, rf_waddr, rf_wdata); end
      step();
      samp();
      checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd5, 32'hA5A5A5A5})
         begin errors++; $display("FAIL wb_hold: got we=%b a=%0d d=%h expected we=0 a=5 d=a5a5a5a5", rf_we, rf_waddr, rf_wdata); end
      $display("test_wb_write: rd=5 data=a5a5a5a5");
   endtask

   task automatic test_scoreboard();
      do_reset();
      issue_valid = 1; issue_rd = 7;
      samp();
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL sb_issue_ok: got %b expected 1", issue_ready); end
      step();
      issue_valid = 0; rs1_addr = 7;
      samp();
      checks++; if (rs_stall !== 1'b1) begin errors++; $display("FAIL sb_stall_set: got %b expected 1", rs_stall); end
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL sb_waw_block: got %b expected 0", issue_ready); end
      step();
      lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h1234;
      samp();
      checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL sb_lsu_ready: got %b expected 1", lsu_ready); end
      step();
      lsu_valid = 0;
      samp();
      checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'h1234})
         begin errors++; $display("FAIL sb_lsu_write: got we=%b a=%0d d=%h expected we=1 a=7 d=1234", rf_we, rf_waddr, rf_wdata); end
      checks++; if (rs_stall !== 1'b1) begin errors++; $display("FAIL sb_stall_hold: got %b expected 1", rs_stall); end
      step();
      samp();
      checks++; if (rs_stall !== 1'b0) begin errors++; $display("FAIL sb_stall_clear: got %b expected 0", rs_stall); end
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL sb_issue_reopen: got %b expected 1", issue_ready); end
      $display("test_scoreboard: rd=7 issue, lsu return 1234");
   endtask

   task automatic test_arbitration();
      do_reset();
      wb_valid = 1; wb_rd = 3; wb_data = 32'h33;
      lsu_valid = 1; lsu_rd = 8; lsu_data = 32'h88;
      mdu_valid = 1; mdu_rd = 9; mdu_data = 32'h99;
      samp();
      checks++; if ({lsu_ready, mdu_ready} !== 2'b00) begin errors++; $display("FAIL arb_c0_ready: got %b expected 00", {lsu_ready, mdu_ready}); end
      step();
      wb_valid = 0;
      samp();
      checks++; if ({lsu_ready, mdu_ready} !== 2'b10) begin errors++; $display("FAIL arb_c1_ready: got %b expected 10", {lsu_ready, mdu_ready}); end
      checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h33})
         begin errors++; $display("FAIL arb_w3: got we=%b a=%0d d=%h expected we=1 a=3 d=33", rf_we, rf_waddr, rf_wdata); end
      step();
      lsu_valid = 0;
      samp();
      checks++; if ({lsu_ready, mdu_ready} !== 2'b01) begin errors++; $display("FAIL arb_c2_ready: got %b expected 01", {lsu_ready, mdu_ready}); end
      checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd8, 32'h88})
         begin errors++; $display("FAIL arb_w8: got we=%b a=%0d d=%h expected we=1 a=8 d=88", rf_we, rf_waddr, rf_wdata); end
      step();
      mdu_valid = 0;
      samp();
      checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 32'h99})
         begin errors++; $display("FAIL arb_w9: got we=%b a=%0d d=%h expected we=1 a=9 d=99", rf_we, rf_waddr, rf_wdata); end
      // pointer now back at LSU: a fresh contention must go to LSU first
      step();
      lsu_valid = 1; lsu_rd = 11; mdu_valid = 1; mdu_rd = 12;
      samp();
      checks++; if ({lsu_ready, mdu_ready} !== 2'b10) begin errors++; $display("FAIL arb_rr_back: got %b expected 10", {lsu_ready, mdu_ready}); end
      step();
      clear_inputs();
      $display("test_arbitration: writes 3, 8, 9");
   endtask

   task automatic test_rd_zero();
      do_reset();
      lsu_valid = 1; lsu_rd = 0; lsu_data = 32'hDEAD;
      mdu_valid = 1; mdu_rd = 4; mdu_data = 32'h44;
      samp();
      checks++; if ({lsu_ready, mdu_ready} !== 2'b11) begin errors++; $display("FAIL rd0_ready: got %b expected 11", {lsu_ready, mdu_ready}); end
      step();
      clear_inputs();
      samp();
      checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd4, 32'h44})
         begin errors++; $display("FAIL rd0_mdu_write: got we=%b a=%0d d=%h expected we=1 a=4 d=44", rf_we, rf_waddr, rf_wdata); end
      step();
      samp();
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rd0_no_extra: got %b expected 0", rf_we); end
      $display("test_rd_zero: lsu rd0 dropped, mdu rd4 written");
   endtask

   task automatic test_sb_err();
      do_reset();
      issue_valid = 1; issue_rd = 10;
      step();
      issue_valid = 0;
      wb_valid = 1; wb_rd = 10; wb_data = 32'hA0;
      samp();
      checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL err_before: got %b expected 0", sb_err); end
      step();
      wb_rd = 2; wb_data = 32'h22;
      samp();
      checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b expected 1", sb_err); end
      checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd10, 32'hA0})
         begin errors++; $display("FAIL err_write: got we=%b a=%0d d=%h expected we=1 a=10 d=a0", rf_we, rf_waddr, rf_wdata); end
      step();
      clear_inputs();
      step();
      samp();
      checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", sb_err); end
      $display("test_sb_err: wb rd=10 while pending");
   endtask

   task automatic test_reset_mid();
      do_reset();
      issue_valid = 1; issue_rd = 12;
      step();
      issue_valid = 0; rs1_addr = 12;
      wb_valid = 1; wb_rd = 12; wb_data = 32'hC0;
      mdu_valid = 1; mdu_rd = 12; mdu_data = 32'h1212;
      samp();
      checks++; if ({mdu_ready, rs_stall} !== 2'b01) begin errors++; $display("FAIL mid_pre: got ready/stall %b expected 01", {mdu_ready, rs_stall}); end
      step();
      wb_valid = 0;
      rst = 1'b1;
      samp();
      checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL mid_err_pre: got %b expected 1", sb_err); end
      step();
      rst = 1'b0;
      clear_inputs();
      rs1_addr = 12; issue_rd = 12;
      samp();
      checks++; if ({rf_we, rs_stall, sb_err, issue_ready} !== 4'b0001)
         begin errors++; $display("FAIL mid_after: got we/stall/err/iready %b expected 0001", {rf_we, rs_stall, sb_err, issue_ready}); end
      for (int i = 0; i < 4; i++) begin
         step();
         samp();
         checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL mid_no_write: cycle %0d got rf_we %b addr %0d expected 0", i, rf_we, rf_waddr); end
      end
      $display("test_reset_mid: rd=12 request dropped");
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_wb_write();
      test_scoreboard();
      test_arbitration();
      test_rd_zero();
      test_sb_err();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
